pwm_decode: RTL and testbench

Measures an incoming PWM waveform and recovers its duty level and period: the receive-side counterpart of the team's fixed-period PWM generator. Samples an asynchronous input, times rising-edge to rising-edge periods and the high time inside each, and publishes one result per period with a strobe. Sits at chip inputs (servo/fan feedback, loopback of our own PWM outputs) feeding control logic.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pwm_decode.sv | 98 +++++++++
 tb/tb_pwm_decode.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM receive path: FSM states and the timeout count.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } pwm_state_e;

    // Counters are WIDTH+1 bits wide; the timeout fires when they reach all-ones.
    function automatic int unsigned tmo_count(input int unsigned width);
        return (32'd1 << (width + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_decode.sv
// Measures an incoming PWM waveform: period between rising edges and high time,
// one registered result per period, with a timeout result while the input is static.
module pwm_decode
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH:0]   period,
    output logic             valid,
    output logic             stale
);

    localparam int unsigned    TMO_INT = tmo_count(WIDTH);
    localparam logic [WIDTH:0] TMO     = TMO_INT[WIDTH:0];
    localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};

    logic           s_sync;
    logic           s;
    logic           s_d;
    logic           rise;
    logic           timeout;
    pwm_state_e     state;
    logic [WIDTH:0] per_cnt;
    logic [WIDTH:0] hi_cnt;
    logic [WIDTH:0] per_inc;
    logic [WIDTH:0] hi_inc;
    logic [WIDTH-1:0] hi_level;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pwm_in),
        .q       (s_sync)
    );

    assign s = s_sync ^ INVERT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise    = s & ~s_d;
    assign timeout = (per_cnt == TMO) & ~rise;

    always_comb begin
        per_inc  = (per_cnt == TMO) ? per_cnt : per_cnt + ONE;
        hi_inc   = (hi_cnt  == TMO) ? hi_cnt  : hi_cnt  + ONE;
        hi_level = hi_cnt[WIDTH] ? '1 : hi_cnt[WIDTH-1:0];
    end

    // The rise cycle itself is the first high cycle of the new period, hence reload to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            per_cnt <= '0;
            hi_cnt  <= '0;
            level   <= '0;
            period  <= '0;
            valid   <= 1'b0;
            stale   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rise) begin
                if (state == MEAS) begin
                    level  <= hi_level;
                    period <= per_cnt;
                    stale  <= 1'b0;
                    valid  <= 1'b1;
                end
                state   <= MEAS;
                per_cnt <= ONE;
                hi_cnt  <= ONE;
            end else if (timeout) begin
                level   <= s ? '1 : '0;
                period  <= '0;
                stale   <= 1'b1;
                valid   <= 1'b1;
                per_cnt <= '0;
                state   <= IDLE;
            end else begin
                per_cnt <= per_inc;
                if (state == MEAS && s) begin
                    hi_cnt <= hi_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_decode.sv
// Bench for pwm_decode: timestamp-based reference model checked every cycle on two
// instances (INVERT=0 and INVERT=1), plus literal expectations for the key scenarios.
module tb_pwm_decode;

    localparam int TMO = 511;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pwm0 = 1'b0;
    logic       pwm1 = 1'b1;
    logic [7:0] lvl0, lvl1;
    logic [8:0] per0, per1;
    logic       v0, v1, st0, st1;

    int checks = 0;
    int errors = 0;
    bit run = 1'b1;

    always #5 clk = ~clk;

    pwm_decode #(.WIDTH(8), .INVERT(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .pwm_in(pwm0),
        .level(lvl0), .period(per0), .valid(v0), .stale(st0)
    );

    pwm_decode #(.WIDTH(8), .INVERT(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pwm_in(pwm1),
        .level(lvl1), .period(per1), .valid(v1), .stale(st1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus generator ----------------
    int mode = 0;       // 0 constant, 1 generator, 2 custom period/high, 3 noise
    bit const_val = 1'b0;
    int gen_level = 64;
    int gen_cnt = 0;
    int c_per = 300;
    int c_hi = 100;
    int c_cnt = 0;
    bit noise_val = 1'b0;

    always @(negedge clk) begin
        bit p;
        gen_cnt = (gen_cnt + 1) % 256;
        c_cnt   = (c_cnt + 1) % c_per;
        if ($urandom_range(7) == 0) noise_val = ~noise_val;
        case (mode)
            0:       p = const_val;
            1:       p = (gen_cnt < gen_level);
            2:       p = (c_cnt < c_hi);
            default: p = noise_val;
        endcase
        pwm0 = p;
        pwm1 = ~p;
    end

    // ---------------- reference model ----------------
    // Time is counted in clock edges since reset; the counter value is derived from
    // the timestamp of the last reference rise or last timeout.
    typedef struct {
        int n;
        bit h_new, h_old;
        bit s_prev;
        bit have_ref;
        int t_ref, t_base;
        int hi;
        bit v;
        int lvl, per;
        bit stl;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.n = 0; m.h_new = 0; m.h_old = 0; m.s_prev = 0; m.have_ref = 0;
        m.t_ref = 0; m.t_base = -1; m.hi = 0;
        m.v = 0; m.lvl = 0; m.per = 0; m.stl = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit pin, input bit inv);
        bit s, rise;
        int cnt;
        s    = m.h_old ^ inv;         // input as seen two edges later
        rise = s && !m.s_prev;
        cnt  = m.have_ref ? (m.n - m.t_ref) : (m.n - m.t_base - 1);
        m.v  = 0;
        if (rise) begin
            if (m.have_ref) begin
                m.v = 1; m.lvl = (m.hi > 255) ? 255 : m.hi; m.per = cnt; m.stl = 0;
            end
            m.have_ref = 1; m.t_ref = m.n; m.hi = 1;
        end else if (cnt >= TMO) begin
            m.v = 1; m.lvl = s ? 255 : 0; m.per = 0; m.stl = 1;
            m.have_ref = 0; m.t_base = m.n;
        end else if (m.have_ref && s) begin
            m.hi++;
        end
        m.s_prev = s;
        m.h_old  = m.h_new;
        m.h_new  = pin;
        m.n++;
        return m;
    endfunction

    mdl_t m0, m1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0 = mdl_reset();
            m1 = mdl_reset();
        end else begin
            m0 = mdl_step(m0, pwm0, 1'b0);
            m1 = mdl_step(m1, pwm1, 1'b1);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run) begin
            chk("d0_valid",  v0,   m0.v);
            chk("d0_level",  lvl0, m0.lvl);
            chk("d0_period", per0, m0.per);
            chk("d0_stale",  st0,  m0.stl);
            chk("d1_valid",  v1,   m1.v);
            chk("d1_level",  lvl1, m1.lvl);
            chk("d1_period", per1, m1.per);
            chk("d1_stale",  st1,  m1.stl);
        end
    end

    // ---------------- directed sequence with literal expectations ----------------
    task automatic wait_valid(input int maxc, input bit fresh, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        while (waited < maxc && !ok) begin
            @(negedge clk);
            waited++;
            if (v0 && (!fresh || !st0)) ok = 1;
        end
        if (!ok) chk("wait_valid_timeout", waited, -1);
    endtask

    initial begin
        int w;
        mode = 0; const_val = 0; reset_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_level", lvl0, 0);
        chk("rst_period", per0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_stale", st0, 0);
        reset_n = 1;

        // static low: timeout result after 512 edges, repeating every 512
        wait_valid(700, 0, w);
        chk("low_first_lat", w, 512);
        chk("low_level", lvl0, 0);
        chk("low_period", per0, 0);
        chk("low_stale", st0, 1);
        wait_valid(700, 0, w);
        chk("low_repeat", w, 512);

        // static high
        const_val = 1;
        wait_valid(1200, 0, w);
        chk("high_level", lvl0, 255);
        chk("high_period", per0, 0);
        chk("high_stale", st0, 1);

        // generator level 64
        mode = 1; gen_level = 64;
        repeat (3) wait_valid(1200, 1, w);
        chk("g64_level", lvl0, 64);
        chk("g64_period", per0, 256);
        chk("g64_stale", st0, 0);
        chk("g64_spacing", w, 256);

        // generator 255 then 1
        gen_level = 255;
        repeat (2) wait_valid(1200, 1, w);
        chk("g255_level", lvl0, 255);
        chk("g255_period", per0, 256);
        gen_level = 1;
        wait_valid(1200, 1, w);
        wait_valid(1200, 1, w);
        chk("g1_level", lvl0, 1);
        chk("g1_period", per0, 256);

        // long high inside 300-cycle period: level clamps
        mode = 2; c_cnt = 0; c_per = 300; c_hi = 299;
        repeat (3) wait_valid(1200, 1, w);
        chk("p300_level", lvl0, 255);
        chk("p300_period", per0, 300);

        // period exactly TMO: rise wins over timeout
        c_cnt = 0; c_per = 511; c_hi = 100;
        repeat (3) wait_valid(1200, 1, w);
        chk("p511_level", lvl0, 100);
        chk("p511_period", per0, 511);
        chk("p511_stale", st0, 0);

        // period longer than TMO: only timeout results
        c_cnt = 0; c_per = 600; c_hi = 400;
        repeat (3) wait_valid(1300, 0, w);
        chk("p600_level", lvl0, 0);
        chk("p600_period", per0, 0);
        chk("p600_stale", st0, 1);

        // randomized periods and duty
        for (int i = 0; i < 8; i++) begin
            c_per = $urandom_range(700, 2);
            c_hi  = $urandom_range(c_per - 1, 1);
            c_cnt = 0;
            repeat (c_per * 3 + 600) @(negedge clk);
        end

        // random toggling
        mode = 3;
        repeat (3000) @(negedge clk);

        // asynchronous reset mid-period
        mode = 1; gen_level = 64;
        repeat (2) wait_valid(1200, 1, w);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #3 reset_n = 0;
        #1;
        chk("arst_level", lvl0, 0);
        chk("arst_period", per0, 0);
        chk("arst_valid", v0, 0);
        @(posedge clk);
        #3 reset_n = 1;
        wait_valid(700, 0, w);
        chk("arst_two_rises", (w > 256) ? 1 : 0, 1);
        chk("arst_level_after", lvl0, 64);
        chk("arst_period_after", per0, 256);
        repeat (300) @(negedge clk);

        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
